// File: rtl/debounce_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pulse_gen_pkg
//   Types and default constants shared by the push-button conditioning blocks.
//   - db_state_e : debounce FSM state encoding (2 bits)
//   - DEF_*      : default debounce / auto-repeat timing
//   - cnt_limit  : largest value representable in a w-bit counter
// ---------------------------------------------------------------------------
package debounce_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CONFIRM_HIGH = 2'd1,
    PRESSED      = 2'd2,
    CONFIRM_LOW  = 2'd3
  } db_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W           = 8;
  localparam int unsigned DEF_REPEAT_DELAY    = 8;
  localparam int unsigned DEF_REPEAT_PERIOD   = 3;

  function automatic int unsigned cnt_limit(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/debounce_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// debounce_pulse_gen_if
//   Button-side bundle of the debouncer.
//   btn_in    : raw asynchronous button level (master -> slave)
//   pulse_out : one-cycle pulse per accepted press / repeat (slave -> master)
//   level_out : debounced button level (slave -> master)
//   busy_out  : an edge is being confirmed (slave -> master)
//   modport master : the environment driving the button
//   modport slave  : the debouncer
// ---------------------------------------------------------------------------
interface debounce_pulse_gen_if;

  logic btn_in;
  logic pulse_out;
  logic level_out;
  logic busy_out;

  modport master (output btn_in, input pulse_out, input level_out, input busy_out);
  modport slave  (input btn_in, output pulse_out, output level_out, output busy_out);

endinterface

// File: rtl/debounce_pulse_gen_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser with asynchronous active-high reset, shared by the
//   input conditioners.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input level
//   q   : synchronised level, two clock edges behind d
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: non-blocking assignments make s1 and q shift together on the same
  // edge; blocking ones would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/debounce_pulse_gen.sv
// ---------------------------------------------------------------------------
// debounce_pulse_gen
//   Synchronises and debounces a raw push-button level and emits one
//   single-cycle pulse per accepted press, used as the count enable of the
//   downstream counter.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : debounce_pulse_gen_if.slave (btn_in in; pulse_out, level_out,
//           busy_out out, all outputs registered)
//   Parameters: DEBOUNCE_CYCLES, CNT_W, REPEAT_DELAY, REPEAT_PERIOD.
//   Build option: define HOLD_REPEAT_EN to auto-repeat pulse_out while the
//   button stays pressed; without it exactly one pulse per press is produced
//   and no repeat logic exists.
// ---------------------------------------------------------------------------
module debounce_pulse_gen
  import debounce_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                reset,
  debounce_pulse_gen_if.slave bus
);

  localparam int unsigned MAX_COUNT =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;

  // Reject configurations where a counter could wrap or a threshold is unreachable.
  generate
    if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY ||
        MAX_COUNT > cnt_limit(CNT_W)) begin : g_bad_cfg
      $error("debounce_pulse_gen: inconsistent DEBOUNCE_CYCLES/CNT_W/REPEAT_* setting");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(DEBOUNCE_CYCLES);

  logic             s2;
  db_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pulse_q;
  logic             level_q;
  logic             busy_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (reset),
    .d   (bus.btn_in),
    .q   (s2)
  );

  // Saturating increment: the sample counter never wraps past its threshold.
  assign cnt_inc = (cnt >= THRESH) ? THRESH : cnt + CNT_ONE;

`ifdef HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] rpt;
  logic [CNT_W-1:0] rpt_inc;

  assign rpt_inc = rpt + CNT_ONE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef HOLD_REPEAT_EN
      rpt     <= '0;
`endif
    end else begin
      pulse_q <= 1'b0;
`ifdef HOLD_REPEAT_EN
      // Only a held PRESSED cycle keeps the repeat count; every other path,
      // including entry into PRESSED, restarts it from zero.
      rpt     <= '0;
`endif
      case (state)
        IDLE: begin
          if (s2) begin
            if (CNT_ONE == THRESH) begin
              state   <= PRESSED;
              cnt     <= '0;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state   <= CONFIRM_HIGH;
              cnt     <= CNT_ONE;
              busy_q  <= 1'b1;
            end
          end
        end

        CONFIRM_HIGH: begin
          if (!s2) begin
            // Bounce rejected: start over without a pulse.
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt_inc == THRESH) begin
            state   <= PRESSED;
            cnt     <= '0;
            pulse_q <= 1'b1;
            level_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        PRESSED: begin
          if (!s2) begin
            if (CNT_ONE == THRESH) begin
              state   <= IDLE;
              cnt     <= '0;
              level_q <= 1'b0;
            end else begin
              state  <= CONFIRM_LOW;
              cnt    <= CNT_ONE;
              busy_q <= 1'b1;
            end
          end
`ifdef HOLD_REPEAT_EN
          else begin
            if (rpt_inc == RPT_FIRST) begin
              pulse_q <= 1'b1;
              rpt     <= RPT_RELOAD;
            end else begin
              rpt     <= rpt_inc;
            end
          end
`endif
        end

        CONFIRM_LOW: begin
          if (s2) begin
            // Release was a bounce: back to PRESSED, level held, no new pulse.
            state  <= PRESSED;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt_inc == THRESH) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.level_out = level_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_debounce_pulse_gen
//   Self-checking bench for debounce_pulse_gen (DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=8, REPEAT_PERIOD=3). A run-length reference model pushes the
//   expected outputs for every clock into a scoreboard queue; a monitor pops
//   and compares on the falling edge. Directed scenarios add latency checks.
//   Honours HOLD_REPEAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_debounce_pulse_gen;

  localparam int D      = 4;
  localparam int DELAY  = 8;
  localparam int PERIOD = 3;

  typedef struct packed {
    logic pulse;
    logic level;
    logic busy;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  debounce_pulse_gen_if bus ();

  debounce_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (8),
    .REPEAT_DELAY    (DELAY),
    .REPEAT_PERIOD   (PERIOD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   tests      = 0;
  int   fails      = 0;
  int   pulse_seen = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a level only flips after D consecutive synchronised
  // samples that disagree with it; any agreeing sample clears the run.
  logic m_s1, m_s2, m_lvl;
  int   m_run;
`ifdef HOLD_REPEAT_EN
  int   m_since;
`endif

  always @(posedge clk) begin : model
    exp_t e;
    logic samp;
    e = '0;
    if (reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_run = 0;
`ifdef HOLD_REPEAT_EN
      m_since = 0;
`endif
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.btn_in;
      if (samp != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl = samp;
          m_run = 0;
          if (samp) begin
            e.pulse = 1'b1;
`ifdef HOLD_REPEAT_EN
            m_since = 0;
`endif
          end
        end
      end else begin
`ifdef HOLD_REPEAT_EN
        if (m_lvl) begin
          if (m_run != 0) m_since = 0;   // release rejected: repeat timing restarts
          else begin
            m_since++;
            if (m_since == DELAY || (m_since > DELAY && (m_since - DELAY) % PERIOD == 0))
              e.pulse = 1'b1;
          end
        end
`endif
        m_run = 0;
      end
      e.level = m_lvl;
      e.busy  = (m_run != 0);
    end
    sb_q.push_back(e);
  end

  // Monitor: compare every presented output triple against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.pulse_out === 1'b1) pulse_seen++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("scoreboard{pulse,level,busy}", {29'd0, bus.pulse_out, bus.level_out, bus.busy_out},
            {29'd0, e.pulse, e.level, e.busy});
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next falling edge (monitor already done).
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    #1 reset = 1'b1;
    #1;
    check("reset_async_outputs", {29'd0, bus.pulse_out, bus.level_out, bus.busy_out}, 32'd0);
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic settle();
    bus.btn_in = 1'b0;
    repeat (14) step();
    check("settled_level", {31'd0, bus.level_out}, 32'd0);
  endtask

  initial begin : stim
    int p0;
    int exp_rep;

    // 1: reset with button held; outputs clear before any clock edge.
    bus.btn_in = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("t1_pulse_in_reset", {31'd0, bus.pulse_out}, 32'd0);
    check("t1_level_in_reset", {31'd0, bus.level_out}, 32'd0);
    check("t1_busy_in_reset",  {31'd0, bus.busy_out},  32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    // Button still held after reset: treated as a fresh press (scoreboarded).
    repeat (10) step();
    settle();

    // 2: press latency, pulse after e5 only.
    bus.btn_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 1) check("t2_busy_e1", {31'd0, bus.busy_out}, 32'd0);
      if (k == 2) check("t2_busy_e2", {31'd0, bus.busy_out}, 32'd1);
      if (k == 4) check("t2_pulse_e4", {30'd0, bus.pulse_out, bus.level_out}, 32'd0);
      if (k == 5) check("t2_pulse_e5", {30'd0, bus.pulse_out, bus.level_out}, 32'd3);
      if (k == 6) check("t2_pulse_e6", {30'd0, bus.pulse_out, bus.level_out}, 32'd1);
    end
    settle();

    // 3: bounce 3 high / 1 low is rejected, then a clean press.
    p0 = pulse_seen;
    bus.btn_in = 1'b1; repeat (3) step();
    bus.btn_in = 1'b0; repeat (1) step();
    bus.btn_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 4) check("t3_pulse_rise4", {31'd0, bus.pulse_out}, 32'd0);
      if (k == 5) check("t3_pulse_rise5", {31'd0, bus.pulse_out}, 32'd1);
    end
    settle();
    check("t3_pulse_count", pulse_seen - p0, 32'd1);

    // 4: short release glitch while pressed, then a real release.
    bus.btn_in = 1'b1;
    repeat (6) step();
    check("t4_pressed_level", {31'd0, bus.level_out}, 32'd1);
    p0 = pulse_seen;
    bus.btn_in = 1'b0; repeat (2) step();
    bus.btn_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_glitch_level", {31'd0, bus.level_out}, 32'd1);
    end
    bus.btn_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 2) check("t4_release_busy", {31'd0, bus.busy_out}, 32'd1);
      if (k == 4) check("t4_release_e4", {31'd0, bus.level_out}, 32'd1);
      if (k == 5) check("t4_release_e5", {31'd0, bus.level_out}, 32'd0);
    end
    check("t4_no_glitch_pulse", pulse_seen - p0, 32'd0);
    settle();

    // 5: reset during CONFIRM_HIGH with the button held.
    bus.btn_in = 1'b1;
    repeat (3) step();
    check("t5_busy_before_reset", {31'd0, bus.busy_out}, 32'd1);
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 4) check("t5_pulse_e4", {31'd0, bus.pulse_out}, 32'd0);
      if (k == 5) check("t5_pulse_e5", {31'd0, bus.pulse_out}, 32'd1);
    end
    settle();

    // 6: long hold; auto-repeat only when built with HOLD_REPEAT_EN.
    p0 = pulse_seen;
    bus.btn_in = 1'b1;
    repeat (30) step();
    settle();
`ifdef HOLD_REPEAT_EN
    exp_rep = 8;
`else
    exp_rep = 1;
`endif
    check("t6_hold_pulse_count", pulse_seen - p0, exp_rep);

    // Randomised bursts with occasional resets, checked by the scoreboard.
    for (int b = 0; b < 300; b++) begin
      int n;
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
      bus.btn_in = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 40)) : int'($urandom_range(1, 6));
      repeat (n) step();
    end
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
